mips_reg_file: RTL

- 32 x 32-bit general-purpose register file for the single-cycle R-type MIPS datapath.
- Sits directly upstream of the ALU bit-slice units (and, or, add, ...). Read ports rs/rt supply ALU input_a/input_b.
- Write port takes the ALU result at the rd address, once per clock.
- Register $0 reads as zero at all times.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/mips_reg_read_port.sv | 53 +++++
 rtl/mips_reg_file.sv | 77 +++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the single-cycle MIPS R-type datapath.
// Instruction field helpers are kept here so the decoder and register file agree on layout.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  // R-type instruction field positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  function automatic reg_addr_t instr_rs(input word_t instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic reg_addr_t instr_rt(input word_t instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

  function automatic reg_addr_t instr_rd(input word_t instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [5:0] instr_opcode(input word_t instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [5:0] instr_funct(input word_t instr);
    return instr[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/mips_reg_read_port.sv
// One combinational read port: zero-register force, out-of-range guard and,
// when REGFILE_BYPASS_EN is defined, a same-cycle write-to-read bypass.
module mips_reg_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS,
  parameter int ADDR_W   = mips_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_regs [NUM_REGS],
`ifdef REGFILE_BYPASS_EN
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
`endif
  output logic [DATA_W-1:0] o_data
);

  logic w_is_zero;
  logic w_in_range;
  logic w_bypass_hit;

  assign w_is_zero  = (i_addr == ADDR_W'(ZERO_REG));
  assign w_in_range = (32'(i_addr) < 32'(NUM_REGS));

`ifdef REGFILE_BYPASS_EN
  assign w_bypass_hit = i_wr_en && (i_wr_addr == i_addr);
`else
  assign w_bypass_hit = 1'b0;
`endif

  // $0 and unimplemented addresses win over the bypass so they always read 0
  always_comb begin
    o_data = '0;
    if (!w_is_zero && w_in_range) begin
      if (w_bypass_hit) begin
        o_data = i_wr_data_sel();
      end else begin
        o_data = i_regs[i_addr];
      end
    end
  end

  function automatic logic [DATA_W-1:0] i_wr_data_sel();
`ifdef REGFILE_BYPASS_EN
    return i_wr_data;
`else
    return '0;
`endif
  endfunction

endmodule

// File: rtl/mips_reg_file.sv
// 32 x 32 MIPS register file: two combinational read ports, one write port, $0 hard-wired to 0.
// Define REGFILE_BYPASS_EN to forward the in-flight write to matching read ports.
module mips_reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS,
  parameter int ADDR_W   = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  logic [DATA_W-1:0] w_regs [NUM_REGS];

  // Entry 0 has no storage; out-of-range write addresses match no entry and are dropped
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_regs[gi] = '0;
      end else begin : g_entry
        logic [DATA_W-1:0] r_q;
        logic              w_wr_sel;

        assign w_wr_sel = wr_en && (rd_addr == ADDR_W'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_q <= '0;
          end else if (w_wr_sel) begin
            r_q <= wr_data;
          end
        end

        assign w_regs[gi] = r_q;
      end
    end
  endgenerate

  mips_reg_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rs_port (
    .i_addr    (rs_addr),
    .i_regs    (w_regs),
`ifdef REGFILE_BYPASS_EN
    .i_wr_en   (wr_en),
    .i_wr_addr (rd_addr),
    .i_wr_data (wr_data),
`endif
    .o_data    (rs_data)
  );

  mips_reg_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rt_port (
    .i_addr    (rt_addr),
    .i_regs    (w_regs),
`ifdef REGFILE_BYPASS_EN
    .i_wr_en   (wr_en),
    .i_wr_addr (rd_addr),
    .i_wr_data (wr_data),
`endif
    .o_data    (rt_data)
  );

endmodule
